// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared types and constants for the system-bus fan-out.
// FSM state enum, window index width, data returned for unmapped/timeout.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR,
    RESP
  } sys_bus_ic_state_t;

  localparam int SYS_BUS_IDX_W = 4;

  localparam logic [63:0] SYS_BUS_UNMAPPED_DATA = '0;

endpackage

// File: rtl/sys_bus_if.sv
// sys_bus_if: simple strobe/ack system bus (addr, wdata, wen, ren, rdata, ack).
// Modport s = bus target side, modport m = bus initiator side.
interface sys_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wen;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          ack;

  modport s (
    input  addr,
    input  wdata,
    input  wen,
    input  ren,
    output rdata,
    output ack
  );

  modport m (
    output addr,
    output wdata,
    output wen,
    output ren,
    input  rdata,
    input  ack
  );

endinterface

// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect: decodes addr[SW+:4] to one of SN windows, registered
// strobes down, registered ack/rdata up, local timeout. Ports: clk, rstn,
// bus (upstream s), bus_m[SN] (downstream m), to_cnt (saturating timeouts).
module sys_bus_interconnect
  import sys_bus_pkg::*;
#(
  parameter int SN = 8,
  parameter int SW = 20,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TO = 64
) (
  input  logic        clk,
  input  logic        rstn,
  sys_bus_if.s        bus,
  sys_bus_if.m        bus_m [SN],
  output logic [15:0] to_cnt
);

  localparam int TW = $clog2(TO + 1);
  localparam int IW = SYS_BUS_IDX_W;
  localparam int NS = 1 << IW;
  localparam logic [IW:0] SN_V = SN[IW:0];
  localparam logic [DW-1:0] NO_DATA =
    DW'(SYS_BUS_UNMAPPED_DATA);

  sys_bus_ic_state_t state;

  logic [IW-1:0] sel;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic          is_wr;
  logic          ack_q;
  logic [DW-1:0] rdata_q;

  logic [SN-1:0] wen_q;
  logic [SN-1:0] ren_q;
  logic [AW-1:0] addr_q  [SN];
  logic [DW-1:0] wdata_q [SN];

  // padded to 16 so any latched index is a legal select
  logic [NS-1:0] s_ack;
  logic [DW-1:0] s_rdata [NS];

  logic [IW-1:0] idx;
  logic          req;
  logic          mapped;
  logic          unused_addr;

  assign idx    = bus.addr[SW +: IW];
  assign req    = bus.wen | bus.ren;
  assign mapped = {1'b0, idx} < SN_V;

  assign unused_addr = ^bus.addr;

  assign timer_nx = timer + TW'(1);

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  for (genvar i = 0; i < NS; i++) begin : g_port
    if (i < SN) begin : g_on
      assign s_ack[i]       = bus_m[i].ack;
      assign s_rdata[i]     = bus_m[i].rdata;
      assign bus_m[i].addr  = addr_q[i];
      assign bus_m[i].wdata = wdata_q[i];
      assign bus_m[i].wen   = wen_q[i];
      assign bus_m[i].ren   = ren_q[i];
    end else begin : g_off
      assign s_ack[i]   = 1'b0;
      assign s_rdata[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sel     <= '0;
      timer   <= '0;
      is_wr   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      wen_q   <= '0;
      ren_q   <= '0;
      to_cnt  <= '0;
      for (int i = 0; i < SN; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      wen_q <= '0;
      ren_q <= '0;
      ack_q <= 1'b0;
      // a new request restarts from any state but ERR,
      // dropping whatever WAIT was tracking
      if (req && state != ERR) begin
        sel   <= idx;
        is_wr <= bus.wen;
        timer <= '0;
        if (mapped) begin
          state <= WAIT;
          for (int i = 0; i < SN; i++) begin
            if (idx == IW'(i)) begin
              addr_q[i]  <= AW'(bus.addr[SW-1:0]);
              wdata_q[i] <= bus.wdata;
              wen_q[i]   <= bus.wen;
              ren_q[i]   <= ~bus.wen;
            end
          end
        end else begin
          state <= ERR;
        end
      end else begin
        case (state)
          WAIT: begin
            if (s_ack[sel]) begin
              state   <= RESP;
              ack_q   <= 1'b1;
              rdata_q <= is_wr ? NO_DATA : s_rdata[sel];
            end else if (timer_nx == TW'(TO)) begin
              state   <= RESP;
              ack_q   <= 1'b1;
              rdata_q <= NO_DATA;
              if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
            end else begin
              timer <= timer_nx;
            end
          end
          ERR: begin
            state   <= RESP;
            ack_q   <= 1'b1;
            rdata_q <= NO_DATA;
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// tb_sys_bus_interconnect: vector table, hand sequences and random
// transactions checked cycle by cycle against a transaction-level model.
module tb_sys_bus_interconnect;

  localparam int SN = 8;
  localparam int TO = 64;

  logic        clk;
  logic        rstn;
  logic [15:0] to_cnt;

  sys_bus_if #(.AW(32), .DW(32)) up ();
  sys_bus_if #(.AW(32), .DW(32)) dn [SN] ();

  sys_bus_interconnect #(
    .SN(SN), .SW(20), .DW(32), .AW(32), .TO(TO)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (up),
    .bus_m (dn),
    .to_cnt(to_cnt)
  );

  logic [SN-1:0] s_ack;
  logic [31:0]   s_rdata [SN];
  logic [SN-1:0] m_wen;
  logic [SN-1:0] m_ren;
  logic [31:0]   m_addr  [SN];
  logic [31:0]   m_wdata [SN];

  for (genvar g = 0; g < SN; g++) begin : g_slv
    assign dn[g].ack   = s_ack[g];
    assign dn[g].rdata = s_rdata[g];
    assign m_wen[g]    = dn[g].wen;
    assign m_ren[g]    = dn[g].ren;
    assign m_addr[g]   = dn[g].addr;
    assign m_wdata[g]  = dn[g].wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mod_addr  [SN];
  logic [31:0] mod_wdata [SN];
  logic [31:0] held;
  logic [15:0] exp_to;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          d;
    int          port;
    logic [31:0] eaddr;
    int          ack_k;
    logic [31:0] erdata;
    int          sp;
    int          sk;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_ports(input int port, input logic first,
                           input logic w, input logic r);
    for (int p = 0; p < SN; p++) begin
      chk($sformatf("wen[%0d]", p), 32'(m_wen[p]),
          32'(first && p == port && w));
      chk($sformatf("ren[%0d]", p), 32'(m_ren[p]),
          32'(first && p == port && !w && r));
      chk($sformatf("addr[%0d]", p), m_addr[p], mod_addr[p]);
      chk($sformatf("wdata[%0d]", p), m_wdata[p], mod_wdata[p]);
    end
  endtask

  // ack_k == 0 means no upstream ack expected within len cycles
  task automatic run_txn(
    input logic w, input logic r,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rd, input int d, input int port,
    input logic [31:0] eaddr, input int ack_k,
    input logic [31:0] erdata, input logic is_to, input int len,
    input int sp, input int sk
  );
    up.wen   = w;
    up.ren   = r;
    up.addr  = addr;
    up.wdata = wdata;
    s_ack    = '0;
    for (int k = 1; k <= len; k++) begin
      tick();
      if (k == 1) begin
        up.wen = 1'b0;
        up.ren = 1'b0;
        if (port >= 0) begin
          mod_addr[port]  = eaddr;
          mod_wdata[port] = wdata;
        end
      end
      if (k == ack_k) begin
        held = erdata;
        if (is_to && exp_to != 16'hFFFF) exp_to++;
      end
      chk("bus_ack", 32'(up.ack), 32'(k == ack_k));
      chk("bus_rdata", up.rdata, held);
      chk("to_cnt", 32'(to_cnt), 32'(exp_to));
      chk_ports(port, k == 1, w, r);
      s_ack = '0;
      if (port >= 0 && k == 1 + d) begin
        s_ack[port]   = 1'b1;
        s_rdata[port] = rd;
      end
      if (sp >= 0 && k == sk) begin
        s_ack[sp]   = 1'b1;
        s_rdata[sp] = $urandom;
      end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    up.wen   = 1'b0;
    up.ren   = 1'b0;
    up.addr  = '0;
    up.wdata = '0;
    s_ack    = '0;
    for (int p = 0; p < SN; p++) begin
      s_rdata[p]   = '0;
      mod_addr[p]  = '0;
      mod_wdata[p] = '0;
    end
    held   = '0;
    exp_to = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0030_0010, 32'hA5A5_0001, 32'h55,
                2, 3, 32'h10, 4, 32'h0, -1, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0010_0004, 32'h0, 32'h1234_5678,
                0, 1, 32'h4, 2, 32'h1234_5678, 2, 1};
    vecs[2] = '{1'b0, 1'b1, 32'h00A0_0000, 32'h0, 32'h0,
                0, -1, 32'h0, 2, 32'h0, 0, 1};
    vecs[3] = '{1'b1, 1'b1, 32'h0060_0008, 32'h0000_BEEF, 32'hDEAD,
                1, 6, 32'h8, 3, 32'h0, -1, 0};
    vecs[4] = '{1'b0, 1'b1, 32'hFF70_0020, 32'h0, 32'hCAFE_0001,
                3, 7, 32'h20, 5, 32'hCAFE_0001, 6, 2};
    vecs[5] = '{1'b0, 1'b1, 32'h00F0_0000, 32'h0, 32'h0,
                0, -1, 32'h0, 2, 32'h0, -1, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h0081_2345, 32'h1111_2222, 32'h0,
                0, -1, 32'h0, 2, 32'h0, -1, 0};
    vecs[7] = '{1'b0, 1'b1, 32'h000F_FFFC, 32'h0, 32'h0BAD_F00D,
                5, 0, 32'hF_FFFC, 7, 32'h0BAD_F00D, -1, 0};

    tick();
    tick();
    chk("rst_ack", 32'(up.ack), 32'h0);
    chk("rst_rdata", up.rdata, 32'h0);
    chk("rst_to_cnt", 32'(to_cnt), 32'h0);
    chk_ports(-1, 1'b0, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata,
              vecs[i].rd, vecs[i].d, vecs[i].port, vecs[i].eaddr,
              vecs[i].ack_k, vecs[i].erdata, 1'b0,
              vecs[i].ack_k + 2, vecs[i].sp, vecs[i].sk);
    end

    // timeout on slave 2, its ack arrives late at N+70
    run_txn(1'b0, 1'b1, 32'h0020_0000, 32'h0, 32'h7777_7777, 69, 2,
            32'h0, 1 + TO, 32'h0, 1'b1, 1 + TO + 8, -1, 0);

    // abort: slave 0 pending, new read to slave 5, slave 0 acks late
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 1000, 0,
            32'h40, 0, 32'h0, 1'b0, 3, -1, 0);
    run_txn(1'b0, 1'b1, 32'h0050_0044, 32'h0, 32'h55AA_55AA, 1, 5,
            32'h44, 3, 32'h55AA_55AA, 1'b0, 6, 0, 1);

    // back-to-back: request lands in the ack cycle
    run_txn(1'b0, 1'b1, 32'h0040_0010, 32'h0, 32'hABCD_0001, 0, 4,
            32'h10, 2, 32'hABCD_0001, 1'b0, 2, -1, 0);
    run_txn(1'b1, 1'b0, 32'h0040_0014, 32'h9999_0000, 32'h0, 0, 4,
            32'h14, 2, 32'h0, 1'b0, 3, -1, 0);

    // asynchronous reset while waiting on slave 2
    run_txn(1'b0, 1'b1, 32'h0020_0100, 32'h0, 32'h0, 1000, 2,
            32'h100, 0, 32'h0, 1'b0, 4, -1, 0);
    #3 rstn = 1'b0;
    #1;
    for (int p = 0; p < SN; p++) begin
      mod_addr[p]  = '0;
      mod_wdata[p] = '0;
    end
    held   = '0;
    exp_to = '0;
    chk("arst_ack", 32'(up.ack), 32'h0);
    chk("arst_rdata", up.rdata, 32'h0);
    chk("arst_to_cnt", 32'(to_cnt), 32'h0);
    chk_ports(-1, 1'b0, 1'b0, 1'b0);
    #1 rstn = 1'b1;
    tick();
    run_txn(1'b0, 1'b1, 32'h0040_0000, 32'h0, 32'h600D_CAFE, 1, 4,
            32'h0, 3, 32'h600D_CAFE, 1'b0, 4, -1, 0);

    // random traffic against the transaction-level model
    for (int t = 0; t < 150; t++) begin
      logic        w, r, never;
      logic [31:0] a, wd, rd, erd;
      int          op, d, port, ak, gap, sp, sk;
      op    = $urandom_range(0, 2);
      w     = (op != 1);
      r     = (op != 0);
      a     = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      never = ($urandom_range(0, 19) == 0);
      d     = never ? 1000 : $urandom_range(0, 6);
      port  = (a[23:20] < SN) ? int'(a[23:20]) : -1;
      if (port < 0) ak = 2;
      else if (never) ak = 1 + TO;
      else ak = 2 + d;
      erd   = (port < 0 || never || w) ? 32'h0 : rd;
      gap   = $urandom_range(0, 3);
      sp    = $urandom_range(0, SN - 1);
      if (sp == port) sp = -1;
      sk    = $urandom_range(1, 8);
      run_txn(w, r, a, wd, rd, d, port, {12'h0, a[19:0]}, ak, erd,
              port >= 0 && never, ak + gap, sp, sk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
